// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the wait-state RAM controller: FSM states, op codes,
// wait counter sizing and the RAM index width helper.
package ram_access_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   localparam int WAIT_STATES_MAX = 15;
   localparam int CNT_W           = 4;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ram_access_ctrl_ram_array.sv
// Single-port synchronous RAM with write enable and a read-enabled output register,
// so the last read word is held until the next read.
module ram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 512,
   parameter int IDX_W      = 9
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [IDX_W-1:0]      addr_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] dout_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= din_i;
      end
      if (re_i) begin
         dout_q <= mem_q[addr_i];
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// RAM behind a request/done handshake with a programmable number of wait states,
// an out-of-range check and a debug override write port that freezes the FSM.
module ram_access_ctrl
   import ram_access_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int DEPTH       = 1 << ADDR_WIDTH,
   parameter int WAIT_STATES = 2
) (
   input  logic                  Clock,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  done,
   output logic                  busy,
   output logic                  error,
   input  logic                  overide,
   input  logic [ADDR_WIDTH-1:0] overide_address,
   input  logic [DATA_WIDTH-1:0] overide_data_in
);

   localparam int                IDX_W   = idx_width(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_LOAD =
      CNT_W'((WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   op_e                   op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  error_q, error_d;
   logic                  zero_q, zero_d;

   logic                  in_range;
   logic                  ovr_in_range;
   logic                  ram_we;
   logic                  ram_re;
   logic [IDX_W-1:0]      ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic [DATA_WIDTH-1:0] ram_dout;

   assign in_range     = ({1'b0, addr_q} < DEPTH_L);
   assign ovr_in_range = ({1'b0, overide_address} < DEPTH_L);

   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         error_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         error_q <= error_d;
         zero_q  <= zero_d;
      end
   end

   // zero_q forces data_out to 0 after reset and after an out-of-range read,
   // since the RAM output register itself is never cleared.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      error_d = 1'b0;
      zero_d  = zero_q;
      if (overide) begin
         error_d = error_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && (read ^ write)) begin
                  op_d    = write ? OP_WRITE : OP_READ;
                  addr_d  = address;
                  wdata_d = data_in;
                  cnt_d   = CNT_LOAD;
                  state_d = (CNT_LOAD != '0) ? ST_WAIT : ST_ACCESS;
               end else if (enable && read && write) begin
                  error_d = 1'b1;
               end
            end
            ST_WAIT: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               state_d = ST_DONE;
               error_d = ~in_range;
               if (op_q == OP_READ) begin
                  zero_d = ~in_range;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Override owns the RAM port whenever asserted; the FSM is frozen meanwhile.
   always_comb begin
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = addr_q[IDX_W-1:0];
      ram_din  = wdata_q;
      if (overide) begin
         ram_we   = ovr_in_range;
         ram_addr = overide_address[IDX_W-1:0];
         ram_din  = overide_data_in;
      end else if (state_q == ST_ACCESS && in_range) begin
         ram_we = (op_q == OP_WRITE);
         ram_re = (op_q == OP_READ);
      end
   end

   ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk_i  (Clock),
      .we_i   (ram_we),
      .re_i   (ram_re),
      .addr_i (ram_addr),
      .din_i  (ram_din),
      .dout_o (ram_dout)
   );

   assign data_out = zero_q ? '0 : ram_dout;
   assign done     = (state_q == ST_DONE) && !overide;
   assign busy     = (state_q != ST_IDLE);
   assign error    = error_q && !overide;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: five controller instances with different depth / wait-state settings,
// driven by hand-written requests with hand-computed latencies and data.
module tb_ram_access_ctrl;

   localparam int N  = 5;
   localparam int AW = 9;
   localparam int DW = 32;

   function automatic int ws_of(input int i);
      case (i)
         2:       return 0;
         3:       return 1;
         4:       return 15;
         default: return 2;
      endcase
   endfunction

   function automatic int depth_of(input int i);
      return (i == 1) ? 256 : 512;
   endfunction

   logic          clk = 1'b0;
   logic          clr    [N];
   logic          en     [N];
   logic          rd     [N];
   logic          wr     [N];
   logic [AW-1:0] addr   [N];
   logic [DW-1:0] din    [N];
   logic [DW-1:0] dout   [N];
   logic          done   [N];
   logic          busy   [N];
   logic          err    [N];
   logic          ov     [N];
   logic [AW-1:0] ov_addr[N];
   logic [DW-1:0] ov_din [N];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      ram_access_ctrl #(
         .DATA_WIDTH  (DW),
         .ADDR_WIDTH  (AW),
         .DEPTH       (depth_of(gi)),
         .WAIT_STATES (ws_of(gi))
      ) dut (
         .Clock           (clk),
         .clear           (clr[gi]),
         .enable          (en[gi]),
         .read            (rd[gi]),
         .write           (wr[gi]),
         .address         (addr[gi]),
         .data_in         (din[gi]),
         .data_out        (dout[gi]),
         .done            (done[gi]),
         .busy            (busy[gi]),
         .error           (err[gi]),
         .overide         (ov[gi]),
         .overide_address (ov_addr[gi]),
         .overide_data_in (ov_din[gi])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Issues one request and counts cycles until done; optionally holds overide
   // for ovr_len cycles starting in cycle ovr_at.
   task automatic do_req(input int idx, input bit is_wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int ovr_at, input int ovr_len,
                         output int cycles, output logic e_at, output logic [DW-1:0] q_at);
      @(negedge clk);
      en[idx]   = 1'b1;
      wr[idx]   = is_wr;
      rd[idx]   = ~is_wr;
      addr[idx] = a;
      din[idx]  = d;
      @(negedge clk);
      en[idx] = 1'b0;
      wr[idx] = 1'b0;
      rd[idx] = 1'b0;
      cycles  = 1;
      while (!done[idx] && cycles < 60) begin
         if (cycles == ovr_at) ov[idx] = 1'b1;
         if (cycles == ovr_at + ovr_len) ov[idx] = 1'b0;
         @(negedge clk);
         cycles++;
      end
      ov[idx] = 1'b0;
      e_at = err[idx];
      q_at = dout[idx];
   endtask

   task automatic ovr_load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      ov[idx]      = 1'b1;
      ov_addr[idx] = a;
      ov_din[idx]  = d;
      @(negedge clk);
      ov[idx] = 1'b0;
   endtask

   initial begin
      int            c;
      logic          e;
      logic [DW-1:0] q;

      for (int i = 0; i < N; i++) begin
         clr[i] = 1'b1; en[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
         addr[i] = '0; din[i] = '0; ov[i] = 1'b0; ov_addr[i] = '0; ov_din[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) clr[i] = 1'b0;
      @(negedge clk);
      check("rst_data_out", dout[0], 32'h0);
      check("rst_done", {31'b0, done[0]}, 32'h0);
      check("rst_busy", {31'b0, busy[0]}, 32'h0);
      check("rst_error", {31'b0, err[0]}, 32'h0);

      // Basic write/read with two wait states: done in cycle 4
      do_req(0, 1'b1, 9'd5, 32'hDEADBEEF, -1, 0, c, e, q);
      check("t1_wr_latency", c, 4);
      check("t1_wr_error", {31'b0, e}, 32'h0);
      @(negedge clk);
      check("t1_done_pulse_end", {31'b0, done[0]}, 32'h0);
      check("t1_busy_end", {31'b0, busy[0]}, 32'h0);
      do_req(0, 1'b0, 9'd5, 32'h0, -1, 0, c, e, q);
      check("t1_rd_latency", c, 4);
      check("t1_rd_data", q, 32'hDEADBEEF);
      do_req(0, 1'b1, 9'd6, 32'h00001234, -1, 0, c, e, q);
      check("t1_hold_after_write", q, 32'hDEADBEEF);

      // Override preload then read back
      ovr_load(0, 9'd0, 32'h11);
      ovr_load(0, 9'd1, 32'h22);
      do_req(0, 1'b0, 9'd0, 32'h0, -1, 0, c, e, q);
      check("t2_rd0", q, 32'h11);
      do_req(0, 1'b0, 9'd1, 32'h0, -1, 0, c, e, q);
      check("t2_rd1", q, 32'h22);

      // Read and write together: error pulse, no access
      @(negedge clk);
      en[0] = 1'b1; rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'd5; din[0] = 32'h0;
      @(negedge clk);
      check("t3_error_high", {31'b0, err[0]}, 32'h1);
      check("t3_no_done", {31'b0, done[0]}, 32'h0);
      check("t3_not_busy", {31'b0, busy[0]}, 32'h0);
      en[0] = 1'b0; rd[0] = 1'b0; wr[0] = 1'b0;
      @(negedge clk);
      check("t3_error_pulse_end", {31'b0, err[0]}, 32'h0);
      do_req(0, 1'b0, 9'd5, 32'h0, -1, 0, c, e, q);
      check("t3_mem_unchanged", q, 32'hDEADBEEF);

      // Clear during WAIT aborts the write
      ovr_load(0, 9'd7, 32'h5555);
      @(negedge clk);
      en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'd7; din[0] = 32'hAAAA;
      @(negedge clk);
      en[0] = 1'b0; wr[0] = 1'b0;
      check("t4_busy_in_wait", {31'b0, busy[0]}, 32'h1);
      check("t4_no_early_done", {31'b0, done[0]}, 32'h0);
      @(negedge clk);
      check("t4_no_done_before_clear", {31'b0, done[0]}, 32'h0);
      clr[0] = 1'b1;
      #1;
      check("t4_clear_async", {31'b0, busy[0]}, 32'h0);
      @(negedge clk);
      clr[0] = 1'b0;
      do_req(0, 1'b0, 9'd7, 32'h0, -1, 0, c, e, q);
      check("t4_rd_latency", c, 4);
      check("t4_old_value", q, 32'h5555);

      // DEPTH=256: boundary, out-of-range read/write, dropped override
      ovr_load(1, 9'd44, 32'h44);
      ovr_load(1, 9'd255, 32'hFF0);
      ovr_load(1, 9'd300, 32'h999);
      do_req(1, 1'b0, 9'd255, 32'h0, -1, 0, c, e, q);
      check("t5_rd_last_word", q, 32'hFF0);
      check("t5_last_no_error", {31'b0, e}, 32'h0);
      do_req(1, 1'b0, 9'd300, 32'h0, -1, 0, c, e, q);
      check("t5_oor_rd_latency", c, 4);
      check("t5_oor_rd_error", {31'b0, e}, 32'h1);
      check("t5_oor_rd_data", q, 32'h0);
      @(negedge clk);
      check("t5_oor_error_pulse_end", {31'b0, err[1]}, 32'h0);
      do_req(1, 1'b1, 9'd300, 32'hBAD, -1, 0, c, e, q);
      check("t5_oor_wr_error", {31'b0, e}, 32'h1);
      do_req(1, 1'b0, 9'd44, 32'h0, -1, 0, c, e, q);
      check("t5_alias_untouched", q, 32'h44);

      // Wait-state sweep and override stretch
      do_req(2, 1'b1, 9'd1, 32'hA0, -1, 0, c, e, q);
      check("t6_ws0_wr_latency", c, 2);
      do_req(2, 1'b0, 9'd1, 32'h0, -1, 0, c, e, q);
      check("t6_ws0_rd_latency", c, 2);
      check("t6_ws0_rd_data", q, 32'hA0);
      do_req(3, 1'b1, 9'd2, 32'hB1, -1, 0, c, e, q);
      check("t6_ws1_wr_latency", c, 3);
      do_req(4, 1'b1, 9'd3, 32'hF00D, -1, 0, c, e, q);
      check("t6_ws15_wr_latency", c, 17);
      ov_addr[4] = 9'd100;
      ov_din[4]  = 32'h77;
      do_req(4, 1'b0, 9'd3, 32'h0, 5, 3, c, e, q);
      check("t6_ws15_stretch_latency", c, 20);
      check("t6_ws15_stretch_data", q, 32'hF00D);
      do_req(4, 1'b0, 9'd100, 32'h0, -1, 0, c, e, q);
      check("t6_ovr_written_mid_wait", q, 32'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
